// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store front-end: bus width, RISC-V funct3
// encodings, FSM state encoding and the access-size helper.
package mem_access_ctrl_pkg;

  localparam int BUS_64 = 64;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  localparam logic [2:0] FUNCT3_SD  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Cache core expects the access size as byte count minus one.
  function automatic logic [2:0] bytes_minus1(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd0;
      2'b01:   return 3'd1;
      2'b10:   return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_extend.sv
// Combinational load-data extension selected by funct3; shared with the
// uncached MMIO load path.
module mem_load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [BUS_64-1:0] i_rdata,
  output logic [BUS_64-1:0] o_data
);

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      FUNCT3_LB:  o_data = {{56{i_rdata[7]}},  i_rdata[7:0]};
      FUNCT3_LH:  o_data = {{48{i_rdata[15]}}, i_rdata[15:0]};
      FUNCT3_LW:  o_data = {{32{i_rdata[31]}}, i_rdata[31:0]};
      FUNCT3_LBU: o_data = {56'd0, i_rdata[7:0]};
      FUNCT3_LHU: o_data = {48'd0, i_rdata[15:0]};
      FUNCT3_LWU: o_data = {32'd0, i_rdata[31:0]};
      default:    o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store front-end driving the cache core req/ack handshake.
// Optional misaligned-access trap enabled by YSYX_210544_MISALIGN_TRAP_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_valid,
  input  logic              i_mem_ren,
  input  logic              i_mem_wen,
  input  logic [2:0]        i_mem_funct3,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_done,
  output logic              o_mem_stall,
  output logic              o_mem_misalign,
  output logic [ADDR_W-1:0] o_cache_core_addr,
  output logic [DATA_W-1:0] o_cache_core_wdata,
  output logic [2:0]        o_cache_core_bytes,
  output logic              o_cache_core_op,
  output logic              o_cache_core_req,
  input  logic [DATA_W-1:0] i_cache_core_rdata,
  input  logic              i_cache_core_ack
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        bytes_q, bytes_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              op_q, op_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;

  logic              mem_access;
  logic              accept;
  logic              misaligned;
  logic [2:0]        bytes_in;
  logic [BUS_64-1:0] ext_data;

  assign mem_access = i_mem_valid & (i_mem_ren | i_mem_wen);
  // The done term keeps the just-finished instruction from being taken twice.
  assign accept     = mem_access & ~done_q;
  assign bytes_in   = bytes_minus1(i_mem_funct3[1:0]);

`ifdef YSYX_210544_MISALIGN_TRAP_EN
  assign misaligned = |(i_mem_addr[2:0] & bytes_in);
`else
  assign misaligned = 1'b0;
`endif

  mem_load_extend u_extend (
    .i_funct3 (funct3_q),
    .i_rdata  (i_cache_core_rdata),
    .o_data   (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    bytes_d    = bytes_q;
    funct3_d   = funct3_q;
    op_d       = op_q;
    req_d      = req_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            done_d     = 1'b1;
            misalign_d = 1'b1;
            rdata_d    = '0;
          end else begin
            addr_d   = i_mem_addr;
            wdata_d  = i_mem_wdata;
            op_d     = i_mem_wen;
            bytes_d  = bytes_in;
            funct3_d = i_mem_funct3;
            req_d    = 1'b1;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (i_cache_core_ack) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          rdata_d = op_q ? '0 : ext_data;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Hold off the next request until the core has dropped ack.
        if (!i_cache_core_ack) state_d = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      bytes_q    <= '0;
      funct3_q   <= '0;
      op_q       <= 1'b0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      bytes_q    <= bytes_d;
      funct3_q   <= funct3_d;
      op_q       <= op_d;
      req_q      <= req_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_mem_rdata        = rdata_q;
  assign o_mem_done         = done_q;
  assign o_mem_stall        = mem_access & ~done_q;
  assign o_mem_misalign     = misalign_q;
  assign o_cache_core_addr  = addr_q;
  assign o_cache_core_wdata = wdata_q;
  assign o_cache_core_bytes = bytes_q;
  assign o_cache_core_op    = op_q;
  assign o_cache_core_req   = req_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural cache-core responder,
// arithmetic load-extension model and per-cycle protocol checker.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_mem_valid = 1'b0;
  logic        i_mem_ren = 1'b0;
  logic        i_mem_wen = 1'b0;
  logic [2:0]  i_mem_funct3 = 3'd0;
  logic [63:0] i_mem_addr = 64'd0;
  logic [63:0] i_mem_wdata = 64'd0;
  logic [63:0] o_mem_rdata;
  logic        o_mem_done;
  logic        o_mem_stall;
  logic        o_mem_misalign;
  logic [63:0] o_cache_core_addr;
  logic [63:0] o_cache_core_wdata;
  logic [2:0]  o_cache_core_bytes;
  logic        o_cache_core_op;
  logic        o_cache_core_req;
  logic [63:0] i_cache_core_rdata = 64'd0;
  logic        i_cache_core_ack = 1'b0;

  mem_access_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .i_mem_valid        (i_mem_valid),
    .i_mem_ren          (i_mem_ren),
    .i_mem_wen          (i_mem_wen),
    .i_mem_funct3       (i_mem_funct3),
    .i_mem_addr         (i_mem_addr),
    .i_mem_wdata        (i_mem_wdata),
    .o_mem_rdata        (o_mem_rdata),
    .o_mem_done         (o_mem_done),
    .o_mem_stall        (o_mem_stall),
    .o_mem_misalign     (o_mem_misalign),
    .o_cache_core_addr  (o_cache_core_addr),
    .o_cache_core_wdata (o_cache_core_wdata),
    .o_cache_core_bytes (o_cache_core_bytes),
    .o_cache_core_op    (o_cache_core_op),
    .o_cache_core_req   (o_cache_core_req),
    .i_cache_core_rdata (i_cache_core_rdata),
    .i_cache_core_ack   (i_cache_core_ack)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [63:0] expAddr = 64'd0;
  logic [63:0] expWdata = 64'd0;
  logic [2:0]  expBytes = 3'd0;
  logic        expOp = 1'b0;
  logic [63:0] expRdata = 64'd0;
  int          ackDelay = 2;
  int          waitCnt = 0;
  int          dropCnt = 0;
  logic        reqPrev = 1'b0;
  logic        pendingDone = 1'b0;
  logic        checkEnable = 1'b1;
  int          reqRises = 0;
  int          doneCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Load result derived from access width and signedness, not a per-funct3 table.
  function automatic logic [63:0] modelExtend(input logic isStore, input logic [2:0] f3,
                                              input logic [63:0] d);
    int bits;
    logic [63:0] mask;
    logic [63:0] v;
    if (isStore) return 64'd0;
    bits = 8 << f3[1:0];
    if (bits == 64) return d;
    mask = (64'd1 << bits) - 64'd1;
    v = d & mask;
    if (!f3[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // Checker and cache-core responder share one process so ack updates and
  // done predictions stay in a fixed order.
  always @(negedge clk) begin
    if (!rst) begin
      i_cache_core_ack = 1'b0;
      waitCnt = 0;
      dropCnt = 0;
      reqPrev = 1'b0;
      pendingDone = 1'b0;
    end else begin
      if (checkEnable) begin
        checkOutput("done", {63'd0, o_mem_done}, {63'd0, pendingDone});
        checkOutput("stall", {63'd0, o_mem_stall},
                    {63'd0, i_mem_valid && (i_mem_ren || i_mem_wen) && !pendingDone});
        checkOutput("misalign", {63'd0, o_mem_misalign}, 64'd0);
        if (o_mem_done) checkOutput("rdata", o_mem_rdata, expRdata);
        if (o_cache_core_req) begin
          checkOutput("coreAddr", o_cache_core_addr, expAddr);
          checkOutput("coreWdata", o_cache_core_wdata, expWdata);
          checkOutput("coreBytes", {61'd0, o_cache_core_bytes}, {61'd0, expBytes});
          checkOutput("coreOp", {63'd0, o_cache_core_op}, {63'd0, expOp});
        end
        if (o_cache_core_req && !reqPrev)
          checkOutput("reqWhileAck", {63'd0, i_cache_core_ack}, 64'd0);
      end
      if (o_cache_core_req && !reqPrev) reqRises++;
      if (o_mem_done) doneCount++;
      reqPrev = o_cache_core_req;
      if (i_cache_core_ack && !o_cache_core_req) begin
        dropCnt++;
        if (dropCnt >= 2) begin
          i_cache_core_ack = 1'b0;
          dropCnt = 0;
        end
      end else if (o_cache_core_req && !i_cache_core_ack) begin
        waitCnt++;
        if (waitCnt >= ackDelay) begin
          i_cache_core_ack = 1'b1;
          waitCnt = 0;
        end
      end
      pendingDone = o_cache_core_req && i_cache_core_ack;
    end
  end

  task automatic setupAccess(input logic [2:0] f3, input logic isLoad, input logic isStore,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [63:0] coreData, input int delay);
    expAddr = addr;
    expWdata = wdata;
    expBytes = 3'((1 << f3[1:0]) - 1);
    expOp = isStore;
    expRdata = modelExtend(isStore, f3, coreData);
    ackDelay = delay;
    i_cache_core_rdata = coreData;
    i_mem_funct3 = f3;
    i_mem_addr = addr;
    i_mem_wdata = wdata;
    i_mem_ren = isLoad;
    i_mem_wen = isStore;
    i_mem_valid = 1'b1;
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic isLoad, input logic isStore,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] coreData, input int delay,
                               input logic [63:0] litRdata);
    logic seen;
    seen = 1'b0;
    setupAccess(f3, isLoad, isStore, addr, wdata, coreData, delay);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_mem_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("doneTimeout", 64'd0, 64'd1);
    else checkOutput("litRdata", o_mem_rdata, litRdata);
    @(posedge clk);
    #1;
    i_mem_valid = 1'b0;
    i_mem_ren = 1'b0;
    i_mem_wen = 1'b0;
  endtask

`ifdef YSYX_210544_MISALIGN_TRAP_EN
  localparam logic [63:0] SW_ADDR = 64'h8000_000C;
`else
  localparam logic [63:0] SW_ADDR = 64'h8000_000E;
`endif

  initial begin
    int r0;
    int d0;
    logic seenReq;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReq", {63'd0, o_cache_core_req}, 64'd0);
    checkOutput("rstDone", {63'd0, o_mem_done}, 64'd0);
    checkOutput("rstStall", {63'd0, o_mem_stall}, 64'd0);
    checkOutput("rstRdata", o_mem_rdata, 64'd0);
    checkOutput("rstAddr", o_cache_core_addr, 64'd0);
    checkOutput("rstBytes", {61'd0, o_cache_core_bytes}, 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(3'b011, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 64'h1122_3344_5566_7788, 2,
                  64'h1122_3344_5566_7788);
    applyStimulus(3'b000, 1'b1, 1'b0, 64'h8000_0003, 64'd0, 64'hA5A5_A5A5_A5A5_A580, 2,
                  64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(3'b100, 1'b1, 1'b0, 64'h8000_0003, 64'd0, 64'hA5A5_A5A5_A5A5_A580, 2,
                  64'h0000_0000_0000_0080);
    applyStimulus(3'b010, 1'b1, 1'b0, 64'h8000_0000, 64'd0, 64'h0000_0000_8000_0000, 3,
                  64'hFFFF_FFFF_8000_0000);
    applyStimulus(3'b001, 1'b1, 1'b0, 64'h8000_0008, 64'd0, 64'h0000_0000_1234_7FFF, 2,
                  64'h0000_0000_0000_7FFF);
    applyStimulus(3'b101, 1'b1, 1'b0, 64'h8000_000A, 64'd0, 64'h0000_0000_FFFF_8001, 2,
                  64'h0000_0000_0000_8001);
    applyStimulus(3'b110, 1'b1, 1'b0, 64'h8000_0004, 64'd0, 64'hFFFF_FFFF_F000_0001, 2,
                  64'h0000_0000_F000_0001);
    applyStimulus(3'b010, 1'b0, 1'b1, SW_ADDR, 64'h0000_0000_DEAD_BEEF, 64'h5555_5555_5555_5555,
                  3, 64'd0);

    // Back-to-back: ren+wen together must behave as a store.
    r0 = reqRises;
    d0 = doneCount;
    applyStimulus(3'b011, 1'b1, 1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF,
                  64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
    applyStimulus(3'b011, 1'b1, 1'b0, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 5,
                  64'h0123_4567_89AB_CDEF);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("b2bReqRises", 64'(reqRises - r0), 64'd2);
    checkOutput("b2bDones", 64'(doneCount - d0), 64'd2);

    seenReq = 1'b0;
    setupAccess(3'b010, 1'b1, 1'b0, 64'h8000_0040, 64'd0, 64'h0000_0000_8000_0000, 20);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_cache_core_req) begin
        seenReq = 1'b1;
        break;
      end
    end
    if (!seenReq) checkOutput("reqTimeout", 64'd0, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midRstReq", {63'd0, o_cache_core_req}, 64'd0);
    checkOutput("midRstDone", {63'd0, o_mem_done}, 64'd0);
    checkOutput("midRstAddr", o_cache_core_addr, 64'd0);
    checkOutput("midRstBytes", {61'd0, o_cache_core_bytes}, 64'd0);
    i_mem_valid = 1'b0;
    i_mem_ren = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(3'b010, 1'b1, 1'b0, 64'h8000_0020, 64'd0, 64'h0000_0000_7FFF_FFFF, 2,
                  64'h0000_0000_7FFF_FFFF);

`ifdef YSYX_210544_MISALIGN_TRAP_EN
    checkEnable = 1'b0;
    r0 = reqRises;
    setupAccess(3'b001, 1'b1, 1'b0, 64'h8000_0001, 64'd0, 64'h0000_0000_FFFF_8000, 2);
    @(negedge clk);
    checkOutput("trapDone", {63'd0, o_mem_done}, 64'd1);
    checkOutput("trapMisalign", {63'd0, o_mem_misalign}, 64'd1);
    checkOutput("trapReq", {63'd0, o_cache_core_req}, 64'd0);
    checkOutput("trapRdata", o_mem_rdata, 64'd0);
    @(posedge clk);
    #1;
    i_mem_valid = 1'b0;
    i_mem_ren = 1'b0;
    @(negedge clk);
    checkOutput("trapDonePulse", {63'd0, o_mem_done}, 64'd0);
    checkOutput("trapMisalignPulse", {63'd0, o_mem_misalign}, 64'd0);
    checkOutput("trapNoReq", 64'(reqRises - r0), 64'd0);
    @(posedge clk);
    #1;
    checkEnable = 1'b1;
`else
    applyStimulus(3'b001, 1'b1, 1'b0, 64'h8000_0001, 64'd0, 64'h0000_0000_FFFF_8000, 2,
                  64'hFFFF_FFFF_FFFF_8000);
`endif

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
